// File: rtl/rr_output_arbiter.sv
// rr_output_arbiter
//   Per-output round-robin arbiter for a two-VC router port. Each cycle the
//   router polarity selects which VC is served; the winner among that VC's
//   requesters is found by a rotating search from that VC's pointer, and a
//   one-cycle registered grant is issued if the VC's output slot is empty.
//   Per-VC saturating counters record how many grants each VC received.
//
// Ports
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   polarity     : VC served this cycle (0 = VC0, 1 = VC1)
//   req_vc0/1    : per-requester request vectors, one per VC
//   ob_ready_vc0/1 : output buffer slot empty, one per VC
//   cnt_clr      : synchronous clear of both grant counters
//   gnt          : registered one-hot grant
//   gnt_vld      : registered, high when gnt is nonzero
//   gnt_idx      : registered binary index of the last granted requester
//   gnt_vc       : registered VC of the last grant
//   gnt_cnt_vc0/1 : saturating grant counters per VC
module rr_output_arbiter #(
    parameter int NREQ = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            polarity,
    input  logic [NREQ-1:0] req_vc0,
    input  logic [NREQ-1:0] req_vc1,
    input  logic            ob_ready_vc0,
    input  logic            ob_ready_vc1,
    input  logic            cnt_clr,
    output logic [NREQ-1:0] gnt,
    output logic            gnt_vld,
    output logic [2:0]      gnt_idx,
    output logic            gnt_vc,
    output logic [CNTW-1:0] gnt_cnt_vc0,
    output logic [CNTW-1:0] gnt_cnt_vc1
);

    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              gnt_vld_q, gnt_vld_d;
    logic [2:0]        gnt_idx_q, gnt_idx_d;
    logic              gnt_vc_q, gnt_vc_d;
    logic [2:0]        ptr0_q, ptr0_d;
    logic [2:0]        ptr1_q, ptr1_d;
    logic [CNTW-1:0]   cnt0_q, cnt0_d;
    logic [CNTW-1:0]   cnt1_q, cnt1_d;

    logic [NREQ-1:0]   act_req;
    logic              act_rdy;
    logic [2:0]        ptr_cur;
    logic [2*NREQ-1:0] req_dbl;
    logic [2*NREQ-1:0] req_rot;
    logic [2:0]        off;
    logic [3:0]        sum;
    logic [2:0]        win;
    logic [2:0]        ptr_nxt;
    logic              fire;

    // Winner search: rotating the doubled request vector right by the
    // pointer puts requester (ptr+k) mod NREQ at bit k, so the lowest set
    // bit of the low NREQ bits is the round-robin offset.
    always_comb begin
        act_req = polarity ? req_vc1 : req_vc0;
        act_rdy = polarity ? ob_ready_vc1 : ob_ready_vc0;
        ptr_cur = polarity ? ptr1_q : ptr0_q;
        req_dbl = {act_req, act_req};
        req_rot = req_dbl >> ptr_cur;
        off     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) off = 3'(k);
        end
        sum = {1'b0, ptr_cur} + {1'b0, off};
        if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
        win     = sum[2:0];
        ptr_nxt = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
        fire    = (|act_req) && act_rdy;
    end

    always_comb begin
        gnt_d     = '0;
        gnt_vld_d = 1'b0;
        gnt_idx_d = gnt_idx_q;
        gnt_vc_d  = gnt_vc_q;
        ptr0_d    = ptr0_q;
        ptr1_d    = ptr1_q;
        if (fire) begin
            gnt_d     = NREQ'(1) << win;
            gnt_vld_d = 1'b1;
            gnt_idx_d = win;
            gnt_vc_d  = polarity;
            if (polarity) ptr1_d = ptr_nxt;
            else          ptr0_d = ptr_nxt;
        end
    end

    // Counters advance on the same edge that registers the grant, so the
    // count seen alongside a grant already includes it. Clear wins.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (cnt_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else if (fire) begin
            if (!polarity && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
            if (polarity && (cnt1_q != '1))  cnt1_d = cnt1_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_idx_q <= '0;
            gnt_vc_q  <= 1'b0;
            ptr0_q    <= '0;
            ptr1_q    <= '0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vc_q  <= gnt_vc_d;
            ptr0_q    <= ptr0_d;
            ptr1_q    <= ptr1_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_vld     = gnt_vld_q;
    assign gnt_idx     = gnt_idx_q;
    assign gnt_vc      = gnt_vc_q;
    assign gnt_cnt_vc0 = cnt0_q;
    assign gnt_cnt_vc1 = cnt1_q;

endmodule

// File: tb/tb_rr_output_arbiter.sv
module tb_rr_output_arbiter;

    localparam int NREQ = 5;
    // Narrow counters so saturation is reachable in a short run.
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            polarity;
    logic [NREQ-1:0] req_vc0, req_vc1;
    logic            ob_ready_vc0, ob_ready_vc1;
    logic            cnt_clr;
    logic [NREQ-1:0] gnt;
    logic            gnt_vld;
    logic [2:0]      gnt_idx;
    logic            gnt_vc;
    logic [CNTW-1:0] gnt_cnt_vc0, gnt_cnt_vc1;

    rr_output_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk          (clk),
        .reset        (reset),
        .polarity     (polarity),
        .req_vc0      (req_vc0),
        .req_vc1      (req_vc1),
        .ob_ready_vc0 (ob_ready_vc0),
        .ob_ready_vc1 (ob_ready_vc1),
        .cnt_clr      (cnt_clr),
        .gnt          (gnt),
        .gnt_vld      (gnt_vld),
        .gnt_idx      (gnt_idx),
        .gnt_vc       (gnt_vc),
        .gnt_cnt_vc0  (gnt_cnt_vc0),
        .gnt_cnt_vc1  (gnt_cnt_vc1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] g;
        logic [2:0]      idx;
        logic            vc;
        logic [CNTW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tot++;
        if (act !== req)
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        else
            n_pass++;
    endtask

    task automatic expect_g(input logic [NREQ-1:0] g, input int idx, input logic vc, input int cnt);
        exp_t e;
        e.g   = g;
        e.idx = 3'(idx);
        e.vc  = vc;
        e.cnt = CNTW'(cnt);
        exp_q.push_back(e);
    endtask

    // Apply inputs for the next rising edge, then return just after it.
    task automatic cyc(input logic pol, input logic [NREQ-1:0] r0, input logic [NREQ-1:0] r1,
                       input logic rd0, input logic rd1, input logic clr);
        polarity     = pol;
        req_vc0      = r0;
        req_vc1      = r1;
        ob_ready_vc0 = rd0;
        ob_ready_vc1 = rd1;
        cnt_clr      = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on every visible grant.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("onehot_inv", {31'd0, ($countones(gnt) <= 1) && (gnt_vld == (|gnt))}, 32'd1);
            if (gnt_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", {29'd0, gnt_idx}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("gnt", {27'd0, gnt}, {27'd0, e.g});
                    chk("gnt_idx", {29'd0, gnt_idx}, {29'd0, e.idx});
                    chk("gnt_vc", {31'd0, gnt_vc}, {31'd0, e.vc});
                    chk("gnt_cnt", {28'd0, (e.vc ? gnt_cnt_vc1 : gnt_cnt_vc0)}, {28'd0, e.cnt});
                end
            end
        end
    end

    initial begin
        int c0, c1;
        reset        = 1'b0;
        polarity     = 1'b0;
        req_vc0      = '0;
        req_vc1      = '0;
        ob_ready_vc0 = 1'b0;
        ob_ready_vc1 = 1'b0;
        cnt_clr      = 1'b0;
        #3;
        chk("rst_gnt", {27'd0, gnt}, 32'd0);
        chk("rst_vld", {31'd0, gnt_vld}, 32'd0);
        chk("rst_idx", {29'd0, gnt_idx}, 32'd0);
        chk("rst_vc", {31'd0, gnt_vc}, 32'd0);
        chk("rst_cnt0", {28'd0, gnt_cnt_vc0}, 32'd0);
        chk("rst_cnt1", {28'd0, gnt_cnt_vc1}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // First edge after release without requests: no grant.
        idle();
        chk("first_edge_novld", {31'd0, gnt_vld}, 32'd0);

        // Single VC0 request on idx 1; afterwards ptr0 = 2.
        expect_g(5'b00010, 1, 1'b0, 1);
        cyc(1'b0, 5'b00010, '0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("idx_hold", {29'd0, gnt_idx}, 32'd1);
        chk("vc_hold", {31'd0, gnt_vc}, 32'd0);
        // ptr0 = 2: search 2,3,4,0 -> idx 0; ptr0 becomes 1.
        expect_g(5'b00001, 0, 1'b0, 2);
        cyc(1'b0, 5'b00011, '0, 1'b1, 1'b0, 1'b0);
        idle();

        // Backpressure: three stalled cycles, then idx 4 and wrap of ptr0.
        repeat (3) cyc(1'b0, 5'b10000, '0, 1'b0, 1'b1, 1'b0);
        chk("bp_novld", {31'd0, gnt_vld}, 32'd0);
        expect_g(5'b10000, 4, 1'b0, 3);
        cyc(1'b0, 5'b10000, '0, 1'b1, 1'b0, 1'b0);
        expect_g(5'b00001, 0, 1'b0, 4);
        cyc(1'b0, 5'b10001, '0, 1'b1, 1'b0, 1'b0);
        idle();

        // Round-robin sweep on VC1 with polarity toggling; VC0 cycles idle
        // even though VC1 requests and VC0 ready are present.
        for (int i = 0; i < 6; i++) begin
            expect_g(5'b00001 << (i % 5), i % 5, 1'b1, i + 1);
            cyc(1'b1, '0, 5'b11111, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, '0, 5'b11111, 1'b1, 1'b1, 1'b0);
            chk("vld_after_pol0", {31'd0, gnt_vld}, 32'd0);
        end
        idle();

        // VC isolation: ptr0 = 1, ptr1 = 1 entering here.
        expect_g(5'b00100, 2, 1'b0, 5);
        cyc(1'b0, 5'b00100, 5'b01000, 1'b1, 1'b1, 1'b0);
        expect_g(5'b01000, 3, 1'b1, 7);
        cyc(1'b1, 5'b00100, 5'b01000, 1'b1, 1'b1, 1'b0);
        // ptr0 = 3 and ptr1 = 4 shown with all-ones requests.
        expect_g(5'b01000, 3, 1'b0, 6);
        cyc(1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1, 1'b0);
        expect_g(5'b10000, 4, 1'b1, 8);
        cyc(1'b1, 5'b11111, 5'b11111, 1'b1, 1'b1, 1'b0);
        idle();

        // Saturation of the VC0 counter (max 15); ptr0 = 4 entering here.
        c0 = 6;
        for (int i = 0; i < 12; i++) begin
            if (c0 < 15) c0++;
            expect_g(5'b00001 << ((4 + i) % 5), (4 + i) % 5, 1'b0, c0);
            cyc(1'b0, 5'b11111, '0, 1'b1, 1'b0, 1'b0);
        end
        chk("sat_cnt0", {28'd0, gnt_cnt_vc0}, 32'd15);
        // Clear with a simultaneous grant: counter reads 0, ptr0 was 1.
        expect_g(5'b00010, 1, 1'b0, 0);
        cyc(1'b0, 5'b11111, '0, 1'b1, 1'b0, 1'b1);
        chk("clr_cnt1", {28'd0, gnt_cnt_vc1}, 32'd0);
        c1 = 1;
        expect_g(5'b00001, 0, 1'b1, c1);
        cyc(1'b1, '0, 5'b00001, 1'b0, 1'b1, 1'b0);
        idle();

        // Reset pulsed while a grant is visible.
        cyc(1'b0, 5'b00100, '0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_vld", {31'd0, gnt_vld}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_gnt", {27'd0, gnt}, 32'd0);
        chk("mid_rst_vld", {31'd0, gnt_vld}, 32'd0);
        chk("mid_rst_idx", {29'd0, gnt_idx}, 32'd0);
        chk("mid_rst_cnt0", {28'd0, gnt_cnt_vc0}, 32'd0);
        chk("mid_rst_cnt1", {28'd0, gnt_cnt_vc1}, 32'd0);
        polarity = 1'b0;
        req_vc0  = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        // Pointers back at 0 on both VCs.
        expect_g(5'b00001, 0, 1'b0, 1);
        cyc(1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1, 1'b0);
        expect_g(5'b00001, 0, 1'b1, 1);
        cyc(1'b1, 5'b11111, 5'b11111, 1'b1, 1'b1, 1'b0);
        repeat (3) idle();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1);
    end

endmodule

// File: doc/rr_output_arbiter.md
RR_OUTPUT_ARBITER -- requirements
Module: rr_output_arbiter

Interface
REQ-001 Parameter NREQ, default 5, number of requesters; index 0=up, 1=down, 2=left, 3=right, 4=NIC.
REQ-002 Parameter CNTW, default 16, grant-counter width.
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-004 Port clk, input, 1, rising-edge clock.
REQ-005 Port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-006 Port polarity, input, 1, router cycle polarity; selects the VC served this cycle (0 = VC0, 1 = VC1).
REQ-007 Port req_vc0, input, NREQ, per-input-buffer request for this output on VC0 (head flit routed here).
REQ-008 Port req_vc1, input, NREQ, same as req_vc0 for VC1.
REQ-009 Port ob_ready_vc0, input, 1, output buffer VC0 slot empty.
REQ-010 Port ob_ready_vc1, input, 1, output buffer VC1 slot empty.
REQ-011 Port cnt_clr, input, 1, synchronous clear of the grant counters.
REQ-012 Port gnt, output, NREQ, registered one-hot grant.
REQ-013 Port gnt_vld, output, 1, registered; high when gnt is nonzero.
REQ-014 Port gnt_idx, output, 3, registered binary index of the granted requester.
REQ-015 Port gnt_vc, output, 1, registered VC of the current grant.
REQ-016 Port gnt_cnt_vc0, output, CNTW, saturating count of VC0 grants.
REQ-017 Port gnt_cnt_vc1, output, CNTW, saturating count of VC1 grants.

Function
REQ-018 The served VC in each cycle SHALL be v = polarity; the active request vector SHALL be req_vcv, and the active ready SHALL be ob_ready_vcv.
REQ-019 The block SHALL keep two independent round-robin pointers, ptr0 and ptr1 (range 0..NREQ-1), one per VC.
REQ-020 Winner: the first index with its active request bit set, searching ptr_v, ptr_v+1, … modulo NREQ.
REQ-021 When the active request vector is nonzero and the active ready is 1 at a rising edge, the block SHALL register gnt = one-hot(winner), gnt_vld = 1, gnt_idx = winner, and gnt_vc = v.
REQ-022 At that same edge, ptr_v SHALL load (winner+1) mod NREQ (wrap 4 -> 0), and the other VC's pointer SHALL be unchanged.
REQ-023 When the active request vector is zero or the active ready is 0, gnt and gnt_vld SHALL register 0, gnt_idx and gnt_vc SHALL hold their values, and both pointers SHALL be unchanged.
REQ-024 Latency SHALL be exactly 1 cycle from a sampled request to a visible grant; a grant SHALL last exactly one cycle and never repeat without a new sampled request.
REQ-025 Requests for VC v SHALL be ignored in cycles where polarity != v; there is no cross-VC grant.
REQ-026 Requesters deassert the granted req bit within 2 cycles; the block SHALL NOT depend on this for correctness.
REQ-027 On a grant with gnt_vc = 0, gnt_cnt_vc0 SHALL increment by 1, saturating at 2^CNTW-1; the same rule SHALL apply to VC1 and gnt_cnt_vc1.
REQ-028 cnt_clr = 1 SHALL zero both counters at the next edge; cnt_clr SHALL take priority over a simultaneous increment.
REQ-029 All NREQ requests active on the same VC SHALL be granted in rotating order, each exactly once per NREQ grants on that VC.
REQ-030 Invariants: gnt is always one-hot or zero, and gnt_vld = |gnt.

Reset
REQ-031 While reset = 0: gnt = 0, gnt_vld = 0, gnt_idx = 0, gnt_vc = 0, ptr0 = ptr1 = 0, and both counters = 0, asynchronously.
REQ-032 Reset asserted mid-operation SHALL drop any visible grant immediately.
REQ-033 After reset is released, the first grant SHALL use pointers at 0.
REQ-034 No grant SHALL issue on the first edge at which reset is sampled high unless a request is present at that edge.

Verification
REQ-035 Single VC0 request: polarity = 0, req_vc0 = 5'b00010, ob_ready_vc0 = 1 -> next cycle gnt = 00010, gnt_idx = 1, gnt_vc = 0; ptr0 = 2; gnt_cnt_vc0 = 1.
REQ-036 Round-robin sweep: req_vc1 = 5'b11111 held, ob_ready_vc1 = 1, polarity toggling -> grants on VC1 cycles in order idx 0, 1, 2, 3, 4, 0; gnt_vld = 0 in every cycle following polarity = 0.
REQ-037 Backpressure: polarity = 0, req_vc0 = 5'b10000, ob_ready_vc0 = 0 for 3 cycles -> gnt = 0 and ptr0 unchanged; ready -> 1 gives idx 4 one cycle later, and ptr0 wraps to 0.
REQ-038 VC isolation: req_vc0 = 5'b00100 and req_vc1 = 5'b01000 both held -> VC0 grants idx 2 and VC1 grants idx 3; ptr0 = 3, ptr1 = 4, with no cross-update.
REQ-039 Counters and reset: a counter preset near max saturates at 16'hFFFF; cnt_clr with a simultaneous grant gives 0; reset pulsed low mid-grant clears all outputs within the same cycle.
